aplic_msi_tx: RTL and testbench

- Multi-domain MSI write engine for the APLIC in MSI delivery mode.
- Accepts MSI requests from NR_DOMAINS interrupt domains (M, S, further nested domains) and arbitrates them round-robin.
- Buffers accepted requests in a shared FIFO and issues each one as a single-beat AXI-lite write on a flat AW/W/B channel set.
- Generalises the fixed single-domain MSI path to N domains, with queuing, write-error reporting and an error counter.

---
 rtl/aplic_msi_tx.sv | 197 +++++++++++++++++++
 tb/tb_aplic_msi_tx.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aplic_msi_tx.sv
// APLIC MSI write engine: round-robin arbitration over NR_DOMAINS requesters,
// a shared request FIFO, and one single-beat AXI-lite write per queued MSI.
module aplic_msi_tx #(
  parameter int NR_DOMAINS = 2,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int EIID_W     = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int DOM_W     = (NR_DOMAINS > 1) ? $clog2(NR_DOMAINS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NR_DOMAINS-1:0]        i_req_valid,
  output logic [NR_DOMAINS-1:0]        o_req_ready,
  input  logic [NR_DOMAINS*ADDR_W-1:0] i_req_addr,
  input  logic [NR_DOMAINS*EIID_W-1:0] i_req_eiid,
  output logic                         o_awvalid,
  input  logic                         i_awready,
  output logic [ADDR_W-1:0]            o_awaddr,
  output logic                         o_wvalid,
  input  logic                         i_wready,
  output logic [DATA_W-1:0]            o_wdata,
  output logic [DATA_W/8-1:0]          o_wstrb,
  input  logic                         i_bvalid,
  output logic                         o_bready,
  input  logic [1:0]                   i_bresp,
  output logic                         o_err_pulse,
  output logic [DOM_W-1:0]             o_err_domain,
  output logic [CNT_W-1:0]             o_err_count,
  output logic                         o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [DOM_W-1:0]      rr_ptr;
  logic [NR_DOMAINS-1:0] grant;
  logic [DOM_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // First pass covers pointer..top, second pass wraps to 0..pointer-1.
    for (int d = 0; d < NR_DOMAINS; d++) begin
      if (!grant_any && i_req_valid[d] && (d >= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_idx = DOM_W'(d);
        grant[d]  = 1'b1;
      end
    end
    for (int d = 0; d < NR_DOMAINS; d++) begin
      if (!grant_any && i_req_valid[d]) begin
        grant_any = 1'b1;
        grant_idx = DOM_W'(d);
        grant[d]  = 1'b1;
      end
    end
  end

  assign o_req_ready = grant & {NR_DOMAINS{!fifo_full}};
  assign push        = grant_any && !fifo_full;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == DOM_W'(NR_DOMAINS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared request FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [EIID_W-1:0] mem_eiid [FIFO_DEPTH];
  logic [DOM_W-1:0]  mem_dom  [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // NOTE: the storage array carries no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_ptr[PTR_W-1:0]] <= i_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      mem_eiid[wr_ptr[PTR_W-1:0]] <= i_req_eiid[int'(grant_idx)*EIID_W +: EIID_W];
      mem_dom[wr_ptr[PTR_W-1:0]]  <= grant_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  logic              aw_done, w_done;
  logic [EIID_W-1:0] cur_eiid;
  logic [DOM_W-1:0]  cur_dom;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        o_awvalid = !aw_done;
        o_wvalid  = !w_done;
        // Both channels may finish in the same cycle as each other.
        if ((aw_done || i_awready) && (w_done || i_wready)) state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        o_bready = 1'b1;
        if (i_bvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      o_awaddr     <= '0;
      cur_eiid     <= '0;
      cur_dom      <= '0;
      o_err_pulse  <= 1'b0;
      o_err_domain <= '0;
      o_err_count  <= '0;
    end else begin
      o_err_pulse <= 1'b0;
      if (pop) begin
        o_awaddr <= mem_addr[rd_ptr[PTR_W-1:0]];
        cur_eiid <= mem_eiid[rd_ptr[PTR_W-1:0]];
        cur_dom  <= mem_dom[rd_ptr[PTR_W-1:0]];
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (o_awvalid && i_awready) aw_done <= 1'b1;
      if (o_wvalid && i_wready)   w_done  <= 1'b1;
      // SLVERR and DECERR both have bresp[1] set; OKAY/EXOKAY do not.
      if (o_bready && i_bvalid && i_bresp[1]) begin
        o_err_pulse  <= 1'b1;
        o_err_domain <= cur_dom;
        if (o_err_count != {CNT_W{1'b1}}) o_err_count <= o_err_count + 1'b1;
      end
    end
  end

  assign o_wdata = DATA_W'(cur_eiid);
  assign o_wstrb = {(DATA_W/8){o_wvalid}};
  assign o_busy  = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_aplic_msi_tx.sv
// Self-checking bench for aplic_msi_tx: a queue-based transaction model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_aplic_msi_tx;

  localparam int NR   = 2;
  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int EW   = 11;
  localparam int FD   = 4;
  localparam int CW   = 2;
  localparam int DOMW = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*EW-1:0]  req_eiid = '0;
  logic              awvalid, wvalid, bready;
  logic              awready = 1'b1, wready = 1'b1, bvalid = 1'b0;
  logic [AW-1:0]     awaddr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp = 2'b00;
  logic              err_pulse, busy;
  logic [DOMW-1:0]   err_domain;
  logic [CW-1:0]     err_count;

  aplic_msi_tx #(
    .NR_DOMAINS(NR), .ADDR_W(AW), .DATA_W(DW), .EIID_W(EW),
    .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_eiid(req_eiid),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_err_pulse(err_pulse), .o_err_domain(err_domain),
    .o_err_count(err_count), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] eiid;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] eiid;
    int            dom;
  } ent_t;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requesters: each domain presents the head of its queue until accepted.
  req_t rq [NR][$];
  bit   acc_seen [NR];
  bit   b_auto = 1'b1;

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < NR; d++) begin
      if (acc_seen[d] && rq[d].size() > 0) rq[d].delete(0);
      acc_seen[d] = 1'b0;
      if (rq[d].size() > 0) begin
        req_valid[d]          = 1'b1;
        req_addr[d*AW +: AW]  = rq[d][0].addr;
        req_eiid[d*EW +: EW]  = rq[d][0].eiid;
      end else begin
        req_valid[d] = 1'b0;
      end
    end
  end

  // Responder: answers B in the same cycle bready is seen when b_auto is set.
  always @(posedge clk) begin
    #2;
    bvalid = b_auto && bready;
  end

  // Transaction model: a queue for the FIFO, a phase for the single
  // outstanding write, and plain counters for the error reporting.
  ent_t mq[$];
  ent_t m_cur;
  int   m_ptr = 0, m_ph = 0, m_edom = 0, m_cnt = 0;
  bit   m_awd, m_wd, m_pulse;
  bit   chk_en = 1'b0;
  bit   prev_aw = 1'b0;
  int   cyc = 0;

  int            acc_dom[$];
  int            acc_cyc[$];
  int            aw_rise[$];
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];

  always @(negedge clk) begin
    logic [NR-1:0] er;
    int            g;
    cyc++;
    er = '0;
    g  = -1;
    if (mq.size() < FD)
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    if (g >= 0) er[g] = 1'b1;

    if (chk_en) begin
      check("req_ready", req_ready, er);
      check("awvalid", awvalid, (m_ph == 1) && !m_awd);
      check("wvalid", wvalid, (m_ph == 1) && !m_wd);
      check("bready", bready, m_ph == 2);
      check("busy", busy, (mq.size() > 0) || (m_ph != 0));
      check("err_pulse", err_pulse, m_pulse);
      check("err_domain", err_domain, m_edom);
      check("err_count", err_count, m_cnt);
      if (m_ph == 1 && !m_awd) check("awaddr", awaddr, m_cur.addr);
      if (m_ph == 1 && !m_wd) begin
        check("wdata", wdata, {{(DW-EW){1'b0}}, m_cur.eiid});
        check("wstrb", wstrb, {(DW/8){1'b1}});
      end
    end

    if (!rst) begin
      for (int d = 0; d < NR; d++)
        if (req_valid[d] && req_ready[d]) begin
          acc_seen[d] = 1'b1;
          acc_dom.push_back(d);
          acc_cyc.push_back(cyc);
        end
      if (awvalid && !prev_aw) aw_rise.push_back(cyc);
      if (awvalid && awready)  aw_log.push_back(awaddr);
      if (wvalid && wready)    w_log.push_back(wdata);
    end
    prev_aw = awvalid;

    if (rst) begin
      mq.delete();
      m_cur   = '0;
      m_ptr   = 0;
      m_ph    = 0;
      m_awd   = 1'b0;
      m_wd    = 1'b0;
      m_pulse = 1'b0;
      m_edom  = 0;
      m_cnt   = 0;
      chk_en  = 1'b1;
    end else begin
      m_pulse = 1'b0;
      case (m_ph)
        0: if (mq.size() > 0) begin
             m_cur = mq.pop_front();
             m_ph  = 1;
             m_awd = 1'b0;
             m_wd  = 1'b0;
           end
        1: begin
             if (awready) m_awd = 1'b1;
             if (wready)  m_wd  = 1'b1;
             if (m_awd && m_wd) m_ph = 2;
           end
        default: if (bvalid) begin
             if (bresp[1]) begin
               m_pulse = 1'b1;
               m_edom  = m_cur.dom;
               if (m_cnt < CMAX) m_cnt++;
             end
             m_ph = 0;
           end
      endcase
      if (g >= 0) begin
        mq.push_back('{addr: req_addr[g*AW +: AW], eiid: req_eiid[g*EW +: EW], dom: g});
        m_ptr = (g + 1) % NR;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    for (int d = 0; d < NR; d++) rq[d].delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int d, input logic [AW-1:0] a, input logic [EW-1:0] e);
    rq[d].push_back('{addr: a, eiid: e});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || rq[0].size() > 0 || rq[1].size() > 0) && n < 300) begin
      step();
      n++;
    end
    check(name, n < 300, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, abase, wbase, awcnt;
    int            exp_dom[4]  = '{0, 1, 0, 1};
    logic [DW-1:0] exp_c[4]    = '{1, 3, 2, 4};
    logic [DW-1:0] exp_bp[6]   = '{10, 20, 11, 21, 12, 22};

    // Reset state
    do_reset();
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_awaddr", awaddr, 0);

    // Single request, zero-wait responder
    awready = 1'b1; wready = 1'b1; b_auto = 1'b1; bresp = 2'b00;
    push(0, 64'h2800_0000, 11'd5);
    n = 0;
    while (!awvalid && n < 20) begin step(); n++; end
    check("t1_aw_seen", n < 20, 1'b1);
    check("t1_wvalid", wvalid, 1'b1);
    check("t1_awaddr", awaddr, 64'h2800_0000);
    check("t1_wdata", wdata, 32'h5);
    check("t1_wstrb", wstrb, 4'hF);
    wait_idle("t1_idle_timeout");
    check("t1_latency", (aw_rise.size() > 0 && acc_cyc.size() > 0) ?
          64'(aw_rise[$] - acc_cyc[$]) : 64'hDEAD, 2);
    check("t1_busy_after", busy, 1'b0);
    check("t1_no_err", err_count, 0);

    // Pointer now at 1: dom1 (EIID 0) wins over dom0 (max EIID)
    push(0, 64'h2800_0004, 11'h7FF);
    push(1, 64'hFFFF_FFFF_FFFF_FFFC, 11'd0);
    wait_idle("t1b_idle_timeout");
    check("t1b_first_eiid0", w_log[w_log.size()-2], 32'h0);
    check("t1b_second_max", w_log[w_log.size()-1], 32'h7FF);
    check("t1b_first_addr", aw_log[aw_log.size()-2], 64'hFFFF_FFFF_FFFF_FFFC);

    // Contention, EXOKAY responses must not count as errors
    do_reset();
    bresp = 2'b01;
    abase = acc_dom.size();
    wbase = w_log.size();
    push(0, 64'h2800_0010, 11'd1);
    push(0, 64'h2800_0014, 11'd2);
    push(1, 64'h2800_0020, 11'd3);
    push(1, 64'h2800_0024, 11'd4);
    wait_idle("t2_idle_timeout");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_grant_%0d", i),
            (acc_dom.size() > abase + i) ? 64'(acc_dom[abase+i]) : 64'hDEAD, exp_dom[i]);
      check($sformatf("t2_write_%0d", i),
            (w_log.size() > wbase + i) ? 64'(w_log[wbase+i]) : 64'hDEAD, exp_c[i]);
    end
    check("t2_no_err", err_count, 0);
    bresp = 2'b00;

    // Backpressure with FIFO full
    do_reset();
    awready = 1'b0;
    abase = acc_dom.size();
    wbase = w_log.size();
    for (int i = 0; i < 3; i++) begin
      push(0, 64'h3000_0000 + 64'(i), 11'(10 + i));
      push(1, 64'h3100_0000 + 64'(i), 11'(20 + i));
    end
    repeat (10) step();
    check("t3_accepted", acc_dom.size() - abase, 5);
    check("t3_ready_low", req_ready, 2'b00);
    check("t3_pending_dom1", req_valid[1], 1'b1);
    check("t3_awvalid_held", awvalid, 1'b1);
    repeat (10) step();
    check("t3_still_5", acc_dom.size() - abase, 5);
    awready = 1'b1;
    wait_idle("t3_idle_timeout");
    check("t3_accepted_all", acc_dom.size() - abase, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_write_%0d", i),
            (w_log.size() > wbase + i) ? 64'(w_log[wbase+i]) : 64'hDEAD, exp_bp[i]);

    // Split handshake: W in SEND cycle 1, AW in SEND cycle 3
    do_reset();
    awready = 1'b0; wready = 1'b0;
    push(1, 64'h2800_1000, 11'd9);
    n = 0;
    while (!awvalid && n < 20) begin step(); n++; end
    check("t4_aw_seen", n < 20, 1'b1);
    wready = 1'b1;
    step();
    check("t4_c2_wvalid", wvalid, 1'b0);
    check("t4_c2_awvalid", awvalid, 1'b1);
    wready = 1'b0;
    step();
    check("t4_c3_awvalid", awvalid, 1'b1);
    check("t4_c3_bready", bready, 1'b0);
    awready = 1'b1;
    step();
    check("t4_c4_awvalid", awvalid, 1'b0);
    check("t4_c4_bready", bready, 1'b1);
    wready = 1'b1;
    wait_idle("t4_idle_timeout");

    // Error reporting and saturation
    do_reset();
    bresp = 2'b10;
    push(1, 64'h2800_2000, 11'd33);
    n = 0;
    while (!err_pulse && n < 30) begin step(); n++; end
    check("t5_pulse_seen", n < 30, 1'b1);
    check("t5_err_domain", err_domain, 1);
    check("t5_err_count", err_count, 1);
    step();
    check("t5_pulse_one_cycle", err_pulse, 1'b0);
    bresp = 2'b11;
    for (int i = 0; i < 4; i++) push(0, 64'h2800_3000 + 64'(4*i), 11'(40 + i));
    wait_idle("t5_idle_timeout");
    check("t5_saturated", err_count, 3);
    check("t5_last_domain", err_domain, 0);
    bresp = 2'b00;

    // Reset while waiting for B with two entries queued
    do_reset();
    b_auto = 1'b0;
    abase = acc_dom.size();
    push(0, 64'h2800_4000, 11'd7);
    push(0, 64'h2800_4004, 11'd8);
    push(0, 64'h2800_4008, 11'd9);
    n = 0;
    while (!bready && n < 20) begin step(); n++; end
    check("t6_bready_seen", n < 20, 1'b1);
    repeat (3) step();
    check("t6_accepted", acc_dom.size() - abase, 3);
    check("t6_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_awvalid", awvalid, 1'b0);
    check("t6_wvalid", wvalid, 1'b0);
    check("t6_bready", bready, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_awaddr", awaddr, 0);
    awcnt = aw_log.size();
    b_auto = 1'b1;
    repeat (10) step();
    check("t6_no_more_aw", aw_log.size(), awcnt);
    check("t6_busy_after", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
